// File: rtl/rr_priority_encoder.sv
// rr_priority_encoder: N-to-log2(N) request encoder with a valid/ready handshake.
// Selects one set bit of the accepted request vector, either by fixed priority
// (lowest index wins) or round-robin (search starts at a rotating pointer).
// The result is registered with status flags and held under backpressure.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   en        block enable; 0 blocks new accepts (held output still drains)
//   din       request vector
//   in_valid  din valid this cycle
//   in_ready  block can accept din this cycle (combinational)
//   out       encoded index of the selected request
//   out_valid out/none/multi are valid
//   out_ready consumer takes out this cycle
//   none      accepted din was all-zero
//   multi     accepted din had two or more bits set
module rr_priority_encoder #(
  parameter int unsigned N    = 8,
  parameter int unsigned W    = $clog2(N),
  parameter int unsigned MODE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] din,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         none,
  output logic         multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_nxt;
  logic [W-1:0] sel_idx;
  logic         sel_found;
  logic         multi_c;
  logic         accept;
  logic [W-1:0] scan_w;
  int unsigned  scan_idx;

  // Accept whenever enabled and the output slot is empty or draining this cycle.
  assign in_ready = en & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Circular scan from ptr; ptr stays 0 in fixed-priority mode, so the same
  // scan yields lowest-index-wins there.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    scan_idx  = 0;
    scan_w    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      scan_idx = (32'(ptr) + i) % N;
      scan_w   = W'(scan_idx);
      if (!sel_found && din[scan_w]) begin
        sel_found = 1'b1;
        sel_idx   = scan_w;
      end
    end
  end

  // Pointer advances to the slot after the winner, wrapping at N-1.
  assign ptr_nxt = (32'(sel_idx) == N - 1) ? '0 : sel_idx + W'(1);

  assign multi_c = ($countones(din) > 1);

  // Result register, flags and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out       <= '0;
      out_valid <= 1'b0;
      none      <= 1'b0;
      multi     <= 1'b0;
      ptr       <= '0;
    end else if (accept) begin
      out       <= sel_idx;
      out_valid <= 1'b1;
      none      <= ~sel_found;
      multi     <= multi_c;
      // An all-zero request leaves the pointer where it was.
      if (MODE == 1 && sel_found) begin
        ptr <= ptr_nxt;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_priority_encoder.sv
module tb_rr_priority_encoder;

  localparam int unsigned N = 8;
  localparam int unsigned W = 3;

  logic         clk;
  logic         rst;
  logic         en;
  logic [N-1:0] din;
  logic         in_valid;
  logic         out_ready;

  logic         in_ready0, out_valid0, none0, multi0;
  logic [W-1:0] out0;
  logic         in_ready1, out_valid1, none1, multi1;
  logic [W-1:0] out1;

  int checks;
  int errors;

  rr_priority_encoder #(.N(N), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
    .in_ready(in_ready0), .out(out0), .out_valid(out_valid0),
    .out_ready(out_ready), .none(none0), .multi(multi0)
  );

  rr_priority_encoder #(.N(N), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .din(din), .in_valid(in_valid),
    .in_ready(in_ready1), .out(out1), .out_valid(out_valid1),
    .out_ready(out_ready), .none(none1), .multi(multi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    en        = 1'b1;
    din       = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;

    // Reset held two cycles with in_valid asserted
    cyc();
    cyc();
    chk("rst_out_valid0", 32'(out_valid0), 32'd0);
    chk("rst_out_valid1", 32'(out_valid1), 32'd0);
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_none0", 32'(none0), 32'd0);
    chk("rst_multi0", 32'(multi0), 32'd0);
    chk("rst_ptr1", 32'(u1.ptr), 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready0", 32'(in_ready0), 32'd1);

    // Fixed priority
    din = 8'b0000_0100; in_valid = 1'b1;
    cyc();
    chk("fp_single_out", 32'(out0), 32'd2);
    chk("fp_single_multi", 32'(multi0), 32'd0);
    chk("fp_single_valid", 32'(out_valid0), 32'd1);
    chk("fp_single_none", 32'(none0), 32'd0);
    chk("fp_ptr_held", 32'(u0.ptr), 32'd0);
    din = 8'b1010_0000;
    cyc();
    chk("fp_multi_out", 32'(out0), 32'd5);
    chk("fp_multi_multi", 32'(multi0), 32'd1);
    chk("fp_b2b_valid", 32'(out_valid0), 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("drain_valid", 32'(out_valid0), 32'd0);
    chk("drain_out_kept", 32'(out0), 32'd5);
    chk("drain_multi_kept", 32'(multi0), 32'd1);

    // Fresh pointer for round-robin
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rr_ptr_start", 32'(u1.ptr), 32'd0);

    // Round-robin, four back-to-back accepts of 1000_0011
    din = 8'b1000_0011; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk("rr1_out", 32'(out1), 32'd0);
    chk("rr1_ptr", 32'(u1.ptr), 32'd1);
    chk("rr1_fp_out", 32'(out0), 32'd0);
    chk("rr1_multi", 32'(multi1), 32'd1);
    cyc();
    chk("rr2_out", 32'(out1), 32'd1);
    chk("rr2_ptr", 32'(u1.ptr), 32'd2);
    cyc();
    chk("rr3_out", 32'(out1), 32'd7);
    chk("rr3_ptr", 32'(u1.ptr), 32'd0);
    chk("rr3_fp_out", 32'(out0), 32'd0);
    cyc();
    chk("rr4_out", 32'(out1), 32'd0);
    chk("rr4_ptr", 32'(u1.ptr), 32'd1);
    chk("rr4_valid", 32'(out_valid1), 32'd1);

    // Drain, then backpressure
    in_valid = 1'b0;
    cyc();
    chk("bp_pre_valid", 32'(out_valid0), 32'd0);
    out_ready = 1'b0; din = 8'b0001_0000; in_valid = 1'b1;
    #1;
    chk("bp_ready_empty", 32'(in_ready0), 32'd1);
    cyc();
    chk("bp_out0", 32'(out0), 32'd4);
    chk("bp_out1", 32'(out1), 32'd4);
    chk("bp_ptr1", 32'(u1.ptr), 32'd5);
    din = 8'b0000_1000;
    #1;
    chk("bp_ready_held", 32'(in_ready0), 32'd0);
    cyc();
    chk("bp_hold_out", 32'(out0), 32'd4);
    chk("bp_hold_valid", 32'(out_valid0), 32'd1);
    cyc();
    chk("bp_hold2_out", 32'(out0), 32'd4);
    chk("bp_hold2_ptr1", 32'(u1.ptr), 32'd5);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_release", 32'(in_ready0), 32'd1);
    cyc();
    chk("bp_new_out0", 32'(out0), 32'd3);
    chk("bp_new_out1", 32'(out1), 32'd3);
    chk("bp_new_ptr1", 32'(u1.ptr), 32'd4);

    // All-zero request
    din = 8'h00;
    cyc();
    chk("zero_none", 32'(none0), 32'd1);
    chk("zero_out", 32'(out0), 32'd0);
    chk("zero_valid", 32'(out_valid0), 32'd1);
    chk("zero_multi", 32'(multi0), 32'd0);
    chk("zero_none1", 32'(none1), 32'd1);
    chk("zero_ptr1", 32'(u1.ptr), 32'd4);

    // Enable low: no accept, held output stays, then drains
    en = 1'b0; din = 8'b0000_0001; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    chk("en0_ready", 32'(in_ready0), 32'd0);
    cyc();
    chk("en0_valid", 32'(out_valid0), 32'd1);
    chk("en0_none", 32'(none0), 32'd1);
    chk("en0_out", 32'(out0), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("en0_ready_drain", 32'(in_ready0), 32'd0);
    cyc();
    chk("en0_drained", 32'(out_valid0), 32'd0);
    chk("en0_ptr1", 32'(u1.ptr), 32'd4);
    en = 1'b1;

    // Reset mid-operation with a held round-robin result
    out_ready = 1'b0; din = 8'b0001_0000; in_valid = 1'b1;
    cyc();
    chk("mid_out1", 32'(out1), 32'd4);
    chk("mid_ptr1", 32'(u1.ptr), 32'd5);
    cyc();
    chk("mid_held_valid", 32'(out_valid1), 32'd1);
    rst = 1'b1;
    cyc();
    chk("mid_rst_valid", 32'(out_valid1), 32'd0);
    chk("mid_rst_ptr", 32'(u1.ptr), 32'd0);
    chk("mid_rst_out", 32'(out1), 32'd0);
    rst = 1'b0; din = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    cyc();
    chk("post_rst_out1", 32'(out1), 32'd0);
    chk("post_rst_ptr1", 32'(u1.ptr), 32'd1);
    chk("post_rst_multi", 32'(multi1), 32'd1);
    chk("post_rst_out0", 32'(out0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_priority_encoder.md
Name: rr_priority_encoder

Overview:
- Parametrised N-to-log2(N) encoder. Generalises the fixed 4-to-2 one-hot encoder.
- Accepts arbitrary (non-one-hot) request vectors through a valid/ready handshake.
- Resolves multiple active bits by fixed-priority or round-robin selection.
- Presents a registered index with status flags. Sits between request sources (interrupt lines, channel requests) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request inputs; legal 2..64.
- W, $clog2(N), index width; derived, not to be overridden.
- MODE, 0, selection policy: 0 = fixed priority (lowest index wins), 1 = round-robin.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; when 0, no new input is accepted.
- din  input  N  request vector.
- in_valid  input  1  din is valid this cycle.
- in_ready  output  1  block can accept din this cycle.
- out  output  W  encoded index of the selected request.
- out_valid  output  1  out and flags are valid.
- out_ready  input  1  consumer accepts out this cycle.
- none  output  1  accepted din was all-zero.
- multi  output  1  accepted din had more than one bit set.

Behaviour:
- Reset (rst=1 at a clk edge): out_valid=0, out=0, none=0, multi=0, rr pointer ptr=0. Reset dominates all other inputs and discards any held result.
- Timing: in_ready is combinational: en & (~out_valid | out_ready). It never depends on in_valid.
- Accept: occurs when in_valid & in_ready at a clk edge. Latency is 1 cycle: out, none, multi and out_valid=1 are registered at the accept edge.
- Hold: while out_valid=1 and out_ready=0, out, none and multi hold stable and in_ready=0. A new din is not accepted.
- Simultaneous drain and accept: out_valid=1 & out_ready=1 & in_valid=1 & en=1 loads the new result in the same edge. out_valid stays 1, so back-to-back throughput is 1 per cycle.
- Drain only: out_valid=1 & out_ready=1 with no accept clears out_valid to 0 next cycle. out and the flags keep their last values.
- en=0: in_ready=0. A held output still drains normally.
- Selection, MODE=0: out = lowest set bit index of din.
- Selection, MODE=1: search starts at index ptr and proceeds circularly ptr, ptr+1, ..., N-1, 0, ..., ptr-1. out = the first set bit found. On the accept, ptr <= (out+1) mod N; wrap from N-1 goes to 0.
- ptr in MODE=0: held at 0.
- none: din==0 gives none=1 and out=0. ptr is unchanged and the result is still presented with out_valid=1.
- multi: multi=1 iff popcount(din)>=2. It is independent of MODE and is evaluated on the accepted din.
- X/Z: out is never driven X or Z. All outputs are always driven with defined values.
- Structure: all state is in one always block on posedge clk. Selection logic is combinational and generic in N; hand-written cases for N are not permitted.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out=0, none=0, multi=0, in_ready=1 after release (en=1).
- Fixed priority (N=8, MODE=0, out_ready=1): din=0000_0100 -> out=2, multi=0 one cycle after accept. Then din=1010_0000 -> out=5, multi=1.
- Round-robin (MODE=1): din=1000_0011 accepted 4 times back-to-back -> out=0,1,7,0 on consecutive cycles; ptr after each accept =1,2,0,1.
- Backpressure: out_ready=0, present din=0001_0000 then din=0000_1000 -> out=4 held, in_ready=0, second din not taken. Raise out_ready -> out=3 appears the next cycle.
- Zero and enable: din=0 -> none=1, out=0, ptr unchanged. With en=0 and in_valid=1 -> in_ready=0 and no change to out or out_valid.
- Reset mid-operation: MODE=1 with ptr=5 and out_valid=1 held under out_ready=0; assert rst -> out_valid=0 and ptr=0. Next din=1111_1111 -> out=0.
